// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issuer: opcodes, datapath widths
// and the issuer FSM state encoding.
package alu_pkg;

    localparam logic [2:0] OP_ADD     = 3'b000;
    localparam logic [2:0] OP_SUB     = 3'b001;
    localparam logic [2:0] OP_MUL     = 3'b010;
    localparam logic [2:0] OP_DIV     = 3'b011;
    localparam logic [2:0] OP_AND     = 3'b100;
    localparam logic [2:0] OP_OR      = 3'b101;
    localparam logic [2:0] OP_XOR     = 3'b110;
    localparam logic [2:0] OP_ILLEGAL = 3'b111;

    localparam int OP_W      = 3;
    localparam int OPERAND_W = 8;
    localparam int RESULT_W  = 16;
    localparam int TIMER_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } issuer_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with registered occupancy count. Push is ignored
// when full and pop is ignored when empty; simultaneous push/pop keeps count.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE = 1;
    localparam logic [PTR_W-1:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Initiator for the ALU start/done handshake: buffers tagged commands, issues
// them one at a time, and returns result/tag/error on a valid/ready response port.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [OP_W-1:0]      cmd_op,
    input  logic [OPERAND_W-1:0] cmd_a,
    input  logic [OPERAND_W-1:0] cmd_b,
    input  logic [TAG_W-1:0]     cmd_tag,
    output logic                 alu_start,
    output logic [OP_W-1:0]      alu_op,
    output logic [OPERAND_W-1:0] alu_a,
    output logic [OPERAND_W-1:0] alu_b,
    input  logic [RESULT_W-1:0]  alu_result,
    input  logic                 alu_done,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [RESULT_W-1:0]  rsp_result,
    output logic [TAG_W-1:0]     rsp_tag,
    output logic                 rsp_err,
    output logic                 timeout_seen
);

    localparam int ENTRY_W = OP_W + 2 * OPERAND_W + TAG_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

    // Handshakes: a transfer happens on any rising edge where valid and ready
    // are both high; valid, once raised, holds its payload until that edge.
    issuer_state_e        state;
    issuer_state_e        state_next;
    logic [ENTRY_W-1:0]   fifo_wdata;
    logic [ENTRY_W-1:0]   fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;
    logic [OP_W-1:0]      head_op;
    logic [OPERAND_W-1:0] head_a;
    logic [OPERAND_W-1:0] head_b;
    logic [TAG_W-1:0]     head_tag;
    logic [TAG_W-1:0]     tag_q;
    logic [TIMER_W-1:0]   timer;
    logic                 pop;
    logic                 pop_illegal;
    logic                 capture;
    logic                 time_out;

    assign fifo_wdata = {cmd_op, cmd_a, cmd_b, cmd_tag};
    assign {head_op, head_a, head_b, head_tag} = fifo_rdata;
    assign cmd_ready  = !fifo_full;
    assign alu_start  = (state == ST_ISSUE);

    alu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cmd_valid),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        pop_illegal = 1'b0;
        capture     = 1'b0;
        time_out    = 1'b0;
        case (state)
            ST_IDLE: begin
                // Only pop into an empty response slot so a capture never stalls.
                if (!fifo_empty && !rsp_valid) begin
                    pop = 1'b1;
                    if (head_op == OP_ILLEGAL) pop_illegal = 1'b1;
                    else                       state_next  = ST_ISSUE;
                end
            end
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT: begin
                if (alu_done) begin
                    capture    = 1'b1;
                    state_next = ST_DRAIN;
                end else if (timer == '0) begin
                    time_out   = 1'b1;
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!alu_done) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            alu_op       <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            tag_q        <= '0;
            timer        <= '0;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_tag      <= '0;
            rsp_err      <= 1'b0;
            timeout_seen <= 1'b0;
        end else begin
            state <= state_next;
            if (pop) begin
                alu_op <= head_op;
                alu_a  <= head_a;
                alu_b  <= head_b;
                tag_q  <= head_tag;
            end
            if (state == ST_ISSUE)                     timer <= TIMER_W'(TIMEOUT - 1);
            else if (state == ST_WAIT && timer != '0)  timer <= timer - TIMER_W'(1);
            if (pop_illegal) begin
                rsp_valid  <= 1'b1;
                rsp_err    <= 1'b1;
                rsp_result <= '0;
                rsp_tag    <= head_tag;
            end else if (capture) begin
                rsp_valid  <= 1'b1;
                rsp_err    <= 1'b0;
                rsp_result <= alu_result;
                rsp_tag    <= tag_q;
            end else if (time_out) begin
                rsp_valid    <= 1'b1;
                rsp_err      <= 1'b1;
                rsp_result   <= '0;
                rsp_tag      <= tag_q;
                timeout_seen <= 1'b1;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    fifo_count_bound: assert property (@(posedge clk) disable iff (reset)
        fifo_count <= CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: programmable-latency ALU model, command driver,
// scoreboard of expected responses, directed scenarios and a summary line.
module tb_alu_cmd_issuer;
    import alu_pkg::*;

    localparam int FIFO_DEPTH = 4;
    localparam int TAG_W      = 4;
    localparam int TIMEOUT    = 8;
    localparam int W          = 1 + RESULT_W + TAG_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [7:0]        cmd_a;
    logic [7:0]        cmd_b;
    logic [TAG_W-1:0]  cmd_tag;
    logic              alu_start;
    logic [2:0]        alu_op;
    logic [7:0]        alu_a;
    logic [7:0]        alu_b;
    logic [15:0]       alu_result;
    logic              alu_done;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [15:0]       rsp_result;
    logic [TAG_W-1:0]  rsp_tag;
    logic              rsp_err;
    logic              timeout_seen;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_word;
    int checks      = 0;
    int errors      = 0;
    int extra_rsp   = 0;
    int start_count = 0;
    bit hold_chk    = 1'b0;

    int          lat_cfg  = 2;
    int          hold_cfg = 1;
    int          lat_cnt;
    int          hold_cnt;
    logic [15:0] res_q;

    alu_cmd_issuer #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .TAG_W      (TAG_W),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_tag      (cmd_tag),
        .alu_start    (alu_start),
        .alu_op       (alu_op),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_result   (alu_result),
        .alu_done     (alu_done),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_tag      (rsp_tag),
        .rsp_err      (rsp_err),
        .timeout_seen (timeout_seen)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [15:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] sa;
        logic signed [15:0] sb;
        sa = {{8{a[7]}}, a};
        sb = {{8{b[7]}}, b};
        case (op)
            3'd0: return sa + sb;
            3'd1: return sa - sb;
            3'd2: return sa * sb;
            3'd3: return (sb == 0) ? 16'hFFFF : sa / sb;
            3'd4: return sa & sb;
            3'd5: return sa | sb;
            3'd6: return sa ^ sb;
            default: return 16'h0000;
        endcase
    endfunction

    // ALU model: done rises lat_cfg cycles after the start cycle and stays
    // high for hold_cfg cycles; lat_cfg=0 never completes. Starts while busy are ignored.
    always @(posedge clk) begin
        if (reset) begin
            alu_done <= 1'b0;
            lat_cnt  <= 0;
            hold_cnt <= 0;
            res_q    <= 16'h0;
        end else begin
            if (alu_start) start_count <= start_count + 1;
            if (alu_start && !alu_done && lat_cnt == 0 && lat_cfg > 0) begin
                res_q <= alu_ref(alu_op, alu_a, alu_b);
                if (lat_cfg == 1) begin
                    alu_done <= 1'b1;
                    hold_cnt <= hold_cfg;
                end else begin
                    lat_cnt <= lat_cfg - 1;
                end
            end else if (lat_cnt != 0) begin
                lat_cnt <= lat_cnt - 1;
                if (lat_cnt == 1) begin
                    alu_done <= 1'b1;
                    hold_cnt <= hold_cfg;
                end
            end
            if (alu_done) begin
                if (hold_cnt <= 1) alu_done <= 1'b0;
                else               hold_cnt <= hold_cnt - 1;
            end
        end
    end
    assign alu_result = alu_done ? res_q : 16'hBAD0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Scoreboard: compare every accepted response against the oldest expectation.
    always @(negedge clk) begin
        if (!reset && rsp_valid) begin
            if (rsp_ready) begin
                if (exp_q.size() == 0) begin
                    extra_rsp++;
                end else begin
                    exp_word = exp_q.pop_front();
                    check("rsp", {rsp_err, rsp_result, rsp_tag}, exp_word);
                end
            end else if (hold_chk && exp_q.size() != 0) begin
                check("rsp_hold", {rsp_err, rsp_result, rsp_tag}, exp_q[0]);
            end
        end
    end

    // kind: 0 = normal result expected, 1 = error response expected, 2 = no response
    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [TAG_W-1:0] tag, input int kind);
        int n;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_tag   = tag;
        if (kind == 0)      exp_q.push_back({1'b0, alu_ref(op, a, b), tag});
        else if (kind == 1) exp_q.push_back({1'b1, 16'h0000, tag});
        n = 0;
        while (!cmd_ready && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) check("cmd_accept_wait", n, 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", exp_q.size(), 0);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic wait_rsp_valid(input int budget);
        int n;
        n = 0;
        while (!rsp_valid && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("rsp_valid_wait", rsp_valid, 1);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_cmd_ready"}, cmd_ready, 1);
        check({pfx, "_alu_start"}, alu_start, 0);
        check({pfx, "_alu_op"}, alu_op, 0);
        check({pfx, "_alu_a"}, alu_a, 0);
        check({pfx, "_alu_b"}, alu_b, 0);
        check({pfx, "_rsp_valid"}, rsp_valid, 0);
        check({pfx, "_rsp_result"}, rsp_result, 0);
        check({pfx, "_rsp_tag"}, rsp_tag, 0);
        check({pfx, "_rsp_err"}, rsp_err, 0);
        check({pfx, "_timeout_seen"}, timeout_seen, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: still running at %0t, limit 1000000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_a     = 8'd0;
        cmd_b     = 8'd0;
        cmd_tag   = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_reset_outputs("reset");

        // Add with start-latency and held-operand checks
        lat_cfg = 2; hold_cfg = 1;
        s = start_count;
        send(OP_ADD, 8'd5, 8'd3, 4'd1, 0);
        check("start_not_yet", alu_start, 0);
        @(posedge clk); #1;
        check("start_latency", alu_start, 1);
        check("issue_op", alu_op, OP_ADD);
        check("issue_a", alu_a, 8'd5);
        check("issue_b", alu_b, 8'd3);
        @(posedge clk); #1;
        check("start_single", alu_start, 0);
        wait_drain(50);
        check("add_starts", start_count - s, 1);

        // Multiply under response backpressure; queued command must wait
        rsp_ready = 1'b0;
        s = start_count;
        send(OP_MUL, 8'hFC, 8'd7, 4'd2, 0);
        send(OP_ADD, 8'd1, 8'd1, 4'd3, 0);
        wait_rsp_valid(50);
        hold_chk = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        hold_chk = 1'b0;
        check("bp_one_start", start_count - s, 1);
        rsp_ready = 1'b1;
        wait_drain(100);
        check("bp_two_starts", start_count - s, 2);

        // Fill the FIFO while the response slot is blocked
        rsp_ready = 1'b0;
        s = start_count;
        for (int i = 0; i < 5; i++) begin
            op = 3'($urandom_range(0, 6));
            a  = 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(0, 255));
            if (op == OP_DIV && b == 8'd0) b = 8'd1;
            send(op, a, b, 4'(i), 0);
        end
        check("fifo_full", cmd_ready, 0);
        repeat (5) begin @(posedge clk); #1; end
        check("fifo_stays_full", cmd_ready, 0);
        check("fill_one_start", start_count - s, 1);
        rsp_ready = 1'b1;
        wait_drain(300);
        check("fill_starts", start_count - s, 5);

        // Illegal opcode: error response without any start
        s = start_count;
        send(OP_ILLEGAL, 8'd1, 8'd2, 4'd9, 1);
        wait_drain(50);
        check("illegal_no_start", start_count - s, 0);
        check("no_timeout_yet", timeout_seen, 0);

        // Timeout after exactly TIMEOUT WAIT cycles
        lat_cfg = 0;
        send(OP_ADD, 8'd4, 8'd4, 4'd5, 1);
        @(posedge clk); #1;
        check("to_start", alu_start, 1);
        repeat (TIMEOUT) begin @(posedge clk); #1; end
        check("to_not_early", rsp_valid, 0);
        @(posedge clk); #1;
        check("to_valid", rsp_valid, 1);
        check("to_sticky", timeout_seen, 1);
        wait_drain(50);

        // Done coincides with the last timer tick: done wins
        lat_cfg = TIMEOUT;
        send(OP_SUB, 8'd10, 8'd20, 4'd6, 0);
        wait_drain(100);
        check("to_still_sticky", timeout_seen, 1);

        // Level-held done: one response per command, no re-trigger
        lat_cfg = 2; hold_cfg = 5;
        s = start_count;
        send(OP_SUB, 8'h80, 8'd1, 4'd10, 0);
        send(OP_XOR, 8'h5A, 8'hC3, 4'd11, 0);
        wait_drain(200);
        check("held_done_starts", start_count - s, 2);

        // Reset in the middle of WAIT aborts silently
        lat_cfg = 0; hold_cfg = 1;
        send(OP_MUL, 8'h12, 8'h34, 4'hC, 2);
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("midwait_reset");
        reset = 1'b0;
        repeat (20) begin @(posedge clk); #1; end

        check("extra_rsp", extra_rsp, 0);
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
